stage3_accumulate: RTL and testbench
====================================

// Module: stage3_accumulate
// PURPOSE
//   Stage 3 of the SD4 MAC pipeline. Consumes the nine registered aligned partial products and shared
//   exp_max from stage2 and reduces them in a 2-stage adder tree. Accumulates the per-beat sums over a
//   multi-beat dot-product group, saturating to ACC_W, and emits one result per group (in_last-delimited).
// PARAMETERS
//   PP_W   16  width of each signed aligned partial product
//   ACC_W  24  signed accumulator / result width (ACC_W >= PP_W+4)
//   CNT_W   8  beat-counter width
// PORTS
//   clk           in   1      clock, rising edge
//   rst           in   1      synchronous reset, active-low
//   in_valid      in   1      aligned_pp_* / exp_max valid this cycle
//   in_last       in   1      final beat of current group (qualified by in_valid)
//   aligned_pp_0..aligned_pp_8  in  PP_W each  signed aligned partial products from stage2
//   exp_max       in   5      signed group exponent accompanying the beat
//   out_valid     out  1      one-cycle pulse: group result on out_* this cycle
//   out_sum       out  ACC_W  signed saturated group sum
//   out_exp       out  5      exp_max captured on the group's first beat
//   out_count     out  CNT_W  beats in group (saturates at 2^CNT_W-1)
//   out_overflow  out  1      accumulator saturated at least once in group
//   out_exp_err   out  1      some beat's exp_max differed from first beat's
// BEHAVIOUR
//   Reset (rst==0 at posedge): all pipeline valids, accumulator, counters, flags and every output -> 0.
//     Reset mid-group discards partial group; no out_valid results from it.
//   Stage A (T+1): sign-extend each pp to PP_W+4; register three 3-input partial sums, valid, last, exp.
//   Stage B (T+2): register tree_sum = sum of the three partials (PP_W+4 bits, cannot overflow).
//   Accumulate (T+3 edge), when stage-B valid:
//     first beat (group empty): acc = sext(tree_sum); cap_exp = exp; count = 1; flags cleared.
//     else acc = sat(acc + sext(tree_sum)), computed at ACC_W+1 then clamped to
//       [-2^(ACC_W-1), 2^(ACC_W-1)-1]; clamp sets overflow (sticky); count++ (saturating);
//       exp != cap_exp sets exp_err (sticky).
//     if last: out_* loaded with post-update values, out_valid=1 for exactly one cycle; group -> empty.
//   Latency: beat with in_valid&in_last at edge T -> out_valid high in cycle after edge T+3.
//   out_* hold last result until next group completes; only out_valid returns to 0.
//   No backpressure: one beat/cycle accepted; back-to-back groups with no bubble (beat after a last
//     beat starts a new group in the same cycle out_valid is set).
//   in_valid=0 cycles (bubbles) are ignored; in_last with in_valid=0 ignored.
//   Single-beat group legal: out_sum = sext(tree_sum), out_count = 1.
// TESTING
//   Hold rst=0 2 cycles, random inputs -> all outputs 0, no out_valid.
//   1 beat, all pp=1, exp_max=3, last -> 3 cycles later out_valid=1, sum=9, count=1, exp=3, flags 0.
//   4 beats pp_k=k (36/beat), last on 4th, then next cycle 1 beat all pp=-1 last -> sum=144,
//     count=4, then pulse one cycle later with sum=-9, count=1.
//   29 beats all pp=16'h7FFF (294903/beat) -> sum=8388607, overflow=1; same with 28 beats -> 8257284, overflow=0.
//   3 beats pp=2 with 2-cycle bubbles and stray in_last while in_valid=0, exp 5,5,6 -> sum=54, count=3, exp=5, exp_err=1.
//   2 beats then rst=0 one cycle, then 1 beat pp=2 last -> single pulse: sum=18, count=1, overflow=0.

Source files
------------

// File: rtl/stage3_accumulate.sv
// Purpose: SD4 MAC stage 3, reducing nine aligned partial products per beat and saturate-accumulating over an in_last group.
// Latency: a beat presented before edge T+1 is in stage A at T+1, in stage B at T+2, and its group result is on out_* after T+3.
// Backpressure: none; one beat per cycle is accepted, bubbles are ignored, and back-to-back groups need no gap.
module stage3_accumulate #(
    parameter int PP_W  = 16,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic signed [PP_W-1:0]  aligned_pp_0,
    input  logic signed [PP_W-1:0]  aligned_pp_1,
    input  logic signed [PP_W-1:0]  aligned_pp_2,
    input  logic signed [PP_W-1:0]  aligned_pp_3,
    input  logic signed [PP_W-1:0]  aligned_pp_4,
    input  logic signed [PP_W-1:0]  aligned_pp_5,
    input  logic signed [PP_W-1:0]  aligned_pp_6,
    input  logic signed [PP_W-1:0]  aligned_pp_7,
    input  logic signed [PP_W-1:0]  aligned_pp_8,
    input  logic signed [4:0]       exp_max,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_sum,
    output logic signed [4:0]       out_exp,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_overflow,
    output logic                    out_exp_err
);

    // Four guard bits hold the sum of nine products without overflow.
    localparam int TW = PP_W + 4;

    localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    function automatic logic signed [TW-1:0] sext_pp(input logic signed [PP_W-1:0] x);
        return {{4{x[PP_W-1]}}, x};
    endfunction

    // Stage A: three 3-input partial sums
    logic                 a_valid;
    logic                 a_last;
    logic signed [4:0]    a_exp;
    logic signed [TW-1:0] a_p0;
    logic signed [TW-1:0] a_p1;
    logic signed [TW-1:0] a_p2;

    // Stage B: the reduced per-beat sum
    logic                 b_valid;
    logic                 b_last;
    logic signed [4:0]    b_exp;
    logic signed [TW-1:0] b_sum;

    // Group accumulation state
    logic                    grp_active;
    logic signed [ACC_W-1:0] acc;
    logic signed [4:0]       cap_exp;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;
    logic                    exp_err;

    // Next-state values of the group state for the beat currently in stage B
    logic signed [ACC_W:0]   tree_ext;
    logic signed [ACC_W:0]   acc_wide;
    logic signed [ACC_W-1:0] nxt_acc;
    logic signed [4:0]       nxt_exp;
    logic [CNT_W-1:0]        nxt_cnt;
    logic                    nxt_ovf;
    logic                    nxt_err;

    // Stage A register: sign-extend the products and form three partial sums.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_valid <= 1'b0;
            a_last  <= 1'b0;
            a_exp   <= '0;
            a_p0    <= '0;
            a_p1    <= '0;
            a_p2    <= '0;
        end else begin
            a_valid <= in_valid;
            a_last  <= in_valid & in_last;
            a_exp   <= exp_max;
            a_p0    <= sext_pp(aligned_pp_0) + sext_pp(aligned_pp_1) + sext_pp(aligned_pp_2);
            a_p1    <= sext_pp(aligned_pp_3) + sext_pp(aligned_pp_4) + sext_pp(aligned_pp_5);
            a_p2    <= sext_pp(aligned_pp_6) + sext_pp(aligned_pp_7) + sext_pp(aligned_pp_8);
        end
    end

    // Stage B register: the final tree level, which cannot overflow TW bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            b_valid <= 1'b0;
            b_last  <= 1'b0;
            b_exp   <= '0;
            b_sum   <= '0;
        end else begin
            b_valid <= a_valid;
            b_last  <= a_last;
            b_exp   <= a_exp;
            b_sum   <= a_p0 + a_p1 + a_p2;
        end
    end

    // Group update: the first beat loads the state, later beats saturate-add and set the sticky flags.
    always_comb begin
        tree_ext = {{(ACC_W+1-TW){b_sum[TW-1]}}, b_sum};
        acc_wide = '0;
        nxt_acc  = acc;
        nxt_exp  = cap_exp;
        nxt_cnt  = cnt;
        nxt_ovf  = ovf;
        nxt_err  = exp_err;
        if (!grp_active) begin
            nxt_acc = tree_ext[ACC_W-1:0];
            nxt_exp = b_exp;
            nxt_cnt = CNT_W'(1);
            nxt_ovf = 1'b0;
            nxt_err = 1'b0;
        end else begin
            acc_wide = {acc[ACC_W-1], acc} + tree_ext;
            if (acc_wide > ACC_MAX) begin
                nxt_acc = ACC_MAX[ACC_W-1:0];
                nxt_ovf = 1'b1;
            end else if (acc_wide < ACC_MIN) begin
                nxt_acc = ACC_MIN[ACC_W-1:0];
                nxt_ovf = 1'b1;
            end else begin
                nxt_acc = acc_wide[ACC_W-1:0];
            end
            nxt_cnt = (&cnt) ? cnt : cnt + CNT_W'(1);
            if (b_exp != cap_exp) begin
                nxt_err = 1'b1;
            end
        end
    end

    // Accumulator and result registers; out_* change only when a group closes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grp_active   <= 1'b0;
            acc          <= '0;
            cap_exp      <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            exp_err      <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_exp      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
            out_exp_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (b_valid) begin
                acc        <= nxt_acc;
                cap_exp    <= nxt_exp;
                cnt        <= nxt_cnt;
                ovf        <= nxt_ovf;
                exp_err    <= nxt_err;
                grp_active <= ~b_last;
                if (b_last) begin
                    out_valid    <= 1'b1;
                    out_sum      <= nxt_acc;
                    out_exp      <= nxt_exp;
                    out_count    <= nxt_cnt;
                    out_overflow <= nxt_ovf;
                    out_exp_err  <= nxt_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage3_accumulate.sv
module tb_stage3_accumulate;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_last;
    logic signed [15:0] pp [9];
    logic signed [4:0]  exp_max;
    logic               out_valid;
    logic signed [23:0] out_sum;
    logic signed [4:0]  out_exp;
    logic [7:0]         out_count;
    logic               out_overflow;
    logic               out_exp_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int sum;
        int exp;
        int cnt;
        int ovf;
        int err;
    } res_t;

    res_t res_q[$];

    typedef struct {
        string name;
        int    beats;
        int    ppv;
        int    e;
        int    sum;
        int    cnt;
        int    ovf;
    } vec_t;

    stage3_accumulate #(.PP_W(16), .ACC_W(24), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .aligned_pp_0 (pp[0]),
        .aligned_pp_1 (pp[1]),
        .aligned_pp_2 (pp[2]),
        .aligned_pp_3 (pp[3]),
        .aligned_pp_4 (pp[4]),
        .aligned_pp_5 (pp[5]),
        .aligned_pp_6 (pp[6]),
        .aligned_pp_7 (pp[7]),
        .aligned_pp_8 (pp[8]),
        .exp_max      (exp_max),
        .out_valid    (out_valid),
        .out_sum      (out_sum),
        .out_exp      (out_exp),
        .out_count    (out_count),
        .out_overflow (out_overflow),
        .out_exp_err  (out_exp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every result pulse, sampled away from the rising edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            res_q.push_back('{sum: int'(out_sum), exp: int'(out_exp), cnt: int'(out_count),
                              ovf: int'(out_overflow), err: int'(out_exp_err)});
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic idle(input int n, input bit stray_last);
        in_valid = 1'b0;
        in_last  = stray_last;
        for (int k = 0; k < 9; k++) pp[k] = 16'($urandom);
        exp_max = 5'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        in_last = 1'b0;
    endtask

    task automatic beat_vec(input int v[9], input int e, input bit last);
        for (int k = 0; k < 9; k++) pp[k] = 16'(v[k]);
        exp_max  = 5'(e);
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic beat_all(input int val, input int e, input bit last);
        int v[9];
        for (int k = 0; k < 9; k++) v[k] = val;
        beat_vec(v, e, last);
    endtask

    task automatic chk_res(input string name, input int idx, input int sum, input int e,
                           input int cnt, input int ovf, input int err);
        if (res_q.size() <= idx) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_present: got %0d results, expected more than %0d", name, res_q.size(), idx);
        end else begin
            chk({name, "_sum"}, res_q[idx].sum, sum);
            chk({name, "_exp"}, res_q[idx].exp, e);
            chk({name, "_cnt"}, res_q[idx].cnt, cnt);
            chk({name, "_ovf"}, res_q[idx].ovf, ovf);
            chk({name, "_err"}, res_q[idx].err, err);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   v[9];

        // 0x7FFF*9 = 294903, 0x8000*9 = -294912, saturation limits are 8388607 / -8388608
        vecs[0] = '{"one_beat",   1,  1,       3,  9,        1,   0};
        vecs[1] = '{"pos_sat29",  29, 32767,   0,  8388607,  29,  1};
        vecs[2] = '{"pos_nosat",  28, 32767,   0,  8257284,  28,  0};
        vecs[3] = '{"neg_small",  3,  -1,      -1, -27,      3,   0};
        vecs[4] = '{"neg_sat30",  30, -32768,  7,  -8388608, 30,  1};
        vecs[5] = '{"cnt_sat",    256, 0,      -16, 0,       255, 0};

        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_max  = '0;
        for (int k = 0; k < 9; k++) pp[k] = '0;

        // Reset held two cycles with random inputs
        repeat (2) begin
            in_valid = 1'($urandom);
            in_last  = 1'($urandom);
            for (int k = 0; k < 9; k++) pp[k] = 16'($urandom);
            exp_max = 5'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_exp", out_exp, 0);
        chk("rst_count", out_count, 0);
        chk("rst_ovf", out_overflow, 0);
        chk("rst_err", out_exp_err, 0);
        rst = 1'b1;
        idle(6, 1'b0);
        chk("rst_no_pulse", res_q.size(), 0);

        // Latency: result appears on the third edge after the beat is presented, for one cycle
        res_q.delete();
        beat_all(1, 3, 1'b1);
        idle(1, 1'b0);
        chk("lat_early", out_valid, 0);
        idle(1, 1'b0);
        chk("lat_valid", out_valid, 1);
        chk("lat_sum", out_sum, 9);
        idle(1, 1'b0);
        chk("lat_pulse_end", out_valid, 0);
        chk("lat_hold_sum", out_sum, 9);

        // Table of uniform-product groups
        foreach (vecs[i]) begin
            res_q.delete();
            for (int b = 0; b < vecs[i].beats; b++)
                beat_all(vecs[i].ppv, vecs[i].e, b == vecs[i].beats - 1);
            idle(6, 1'b0);
            chk({vecs[i].name, "_npulse"}, res_q.size(), 1);
            chk_res(vecs[i].name, 0, vecs[i].sum, vecs[i].e, vecs[i].cnt, vecs[i].ovf, 0);
        end

        // Back-to-back groups: four beats of pp_k=k, then a single all -1 beat with no gap
        res_q.delete();
        for (int k = 0; k < 9; k++) v[k] = k;
        for (int b = 0; b < 4; b++) beat_vec(v, 1, b == 3);
        beat_all(-1, 2, 1'b1);
        idle(6, 1'b0);
        chk("b2b_npulse", res_q.size(), 2);
        chk_res("b2b_g0", 0, 144, 1, 4, 0, 0);
        chk_res("b2b_g1", 1, -9, 2, 1, 0, 0);

        // Bubbles with stray in_last while invalid, exponent changes on the last beat
        res_q.delete();
        beat_all(2, 5, 1'b0);
        idle(2, 1'b1);
        beat_all(2, 5, 1'b0);
        idle(2, 1'b1);
        beat_all(2, 6, 1'b1);
        idle(6, 1'b0);
        chk("bub_npulse", res_q.size(), 1);
        chk_res("bub", 0, 54, 5, 3, 0, 1);

        // Reset mid-group discards the partial group
        res_q.delete();
        beat_all(2, 0, 1'b0);
        beat_all(2, 0, 1'b0);
        rst = 1'b0;
        idle(1, 1'b0);
        rst = 1'b1;
        beat_all(2, 0, 1'b1);
        idle(6, 1'b0);
        chk("rstmid_npulse", res_q.size(), 1);
        chk_res("rstmid", 0, 18, 0, 1, 0, 0);
        idle(3, 1'b0);
        chk("hold_valid", out_valid, 0);
        chk("hold_sum", out_sum, 18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
